// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive / serialiser datapath.
package ps2_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SHL  = 2'd1,
    SHR  = 2'd2,
    LOAD = 2'd3
  } shift_mode_t;

  localparam int PS2_FRAME_LEN = 11;

endpackage

// File: rtl/frame_counter.sv
// Counts shifts within a frame and emits a registered one-cycle pulse
// after the FRAME_LEN-th shift, wrapping straight into the next frame.
module frame_counter #(
  parameter int FRAME_LEN = 11,
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap_pulse
);

  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          wrap_reg, wrap_next;

  always_comb begin
    cnt_next  = cnt_reg;
    wrap_next = 1'b0;
    if (clr) begin
      cnt_next = '0;
    end else if (inc) begin
      // The completing shift restarts the count so the next shift is bit 1.
      if (cnt_reg == LAST) begin
        cnt_next  = '0;
        wrap_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      wrap_reg <= wrap_next;
    end
  end

  assign cnt        = cnt_reg;
  assign wrap_pulse = wrap_reg;

endmodule

// File: rtl/shift_reg_framer.sv
// Bidirectional shift/load register with frame counting and live parity,
// used for PS/2 receive (SHR, LSB first) or as a transmit serialiser.
module shift_reg_framer
  import ps2_pkg::*;
#(
  parameter int N         = 11,
  parameter int FRAME_LEN = N,
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clear,
  input  shift_mode_t   mode,
  input  logic          sin,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic          sout_l,
  output logic          sout_r,
  output logic [CW-1:0] bit_cnt,
  output logic          frame_done,
  output logic          parity
);

  logic [N-1:0] q_reg, q_next;
  logic         is_shift, is_load;

  assign is_shift = en && ((mode == SHL) || (mode == SHR));
  assign is_load  = en && (mode == LOAD);

  always_comb begin
    q_next = q_reg;
    if (clear) begin
      q_next = '0;
    end else if (en) begin
      case (mode)
        SHL:     q_next = {q_reg[N-2:0], sin};
        SHR:     q_next = {sin, q_reg[N-1:1]};
        LOAD:    q_next = d;
        default: q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  // A load restarts the frame just like a clear does.
  frame_counter #(
    .FRAME_LEN(FRAME_LEN),
    .CW       (CW)
  ) u_frame_counter (
    .clk       (clk),
    .reset     (reset),
    .clr       (clear | is_load),
    .inc       (is_shift),
    .cnt       (bit_cnt),
    .wrap_pulse(frame_done)
  );

  assign q      = q_reg;
  assign sout_l = q_reg[N-1];
  assign sout_r = q_reg[0];
  assign parity = ^q_reg;

endmodule

// File: tb/tb_shift_reg_framer.sv
// Self-checking bench: directed table, multi-cycle corner sequences, and a
// randomized run against an arithmetic reference model.
module tb_shift_reg_framer;
  import ps2_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  shift_mode_t mode = HOLD;
  logic        sin = 1'b0;
  logic [10:0] d = '0;

  logic [10:0] q, q3;
  logic        sout_l, sout_r, sout_l3, sout_r3;
  logic [3:0]  bit_cnt;
  logic [1:0]  bit_cnt3;
  logic        frame_done, frame_done3, parity, parity3;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_reg_framer #(.N(11)) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .mode(mode), .sin(sin), .d(d),
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .bit_cnt(bit_cnt),
    .frame_done(frame_done), .parity(parity)
  );

  shift_reg_framer #(.N(11), .FRAME_LEN(3)) dut3 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .mode(mode), .sin(sin), .d(d),
    .q(q3), .sout_l(sout_l3), .sout_r(sout_r3), .bit_cnt(bit_cnt3),
    .frame_done(frame_done3), .parity(parity3)
  );

  typedef struct {
    logic        clr;
    logic        en;
    shift_mode_t mode;
    logic        sin;
    logic [10:0] d;
    logic [10:0] eq;
    logic [3:0]  ecnt;
    logic        efd;
    logic        esl;
    logic        esr;
    logic        epar;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock transaction; inputs change 1 ns after an edge, outputs read 1 ns after the next.
  task automatic cyc(input logic c, input logic e, input shift_mode_t m, input logic s,
                     input logic [10:0] dd);
    clear = c; en = e; mode = m; sin = s; d = dd;
    @(posedge clk);
    #1;
    $display("cyc t=%0t clr=%0b en=%0b mode=%s sin=%0b d=%03h -> q=%03h cnt=%0d fd=%0b | q3=%03h cnt3=%0d fd3=%0b",
             $time, c, e, m.name(), s, dd, q, bit_cnt, frame_done, q3, bit_cnt3, frame_done3);
  endtask

  // Reference model: register value as an integer, frame position as total shifts since load.
  int mq, ms11, ms3;
  bit mfd11, mfd3;

  task automatic model_step(input logic c, input logic e, input shift_mode_t m, input logic s,
                            input logic [10:0] dd);
    if (c) begin
      mq = 0; ms11 = 0; ms3 = 0; mfd11 = 0; mfd3 = 0;
    end else if (e && m == LOAD) begin
      mq = int'(dd); ms11 = 0; ms3 = 0; mfd11 = 0; mfd3 = 0;
    end else if (e && (m == SHL || m == SHR)) begin
      if (m == SHL) mq = (mq * 2 + int'(s)) % 2048;
      else          mq = mq / 2 + int'(s) * 1024;
      ms11++; ms3++;
      mfd11 = (ms11 % 11 == 0);
      mfd3  = (ms3 % 3 == 0);
    end else begin
      mfd11 = 0; mfd3 = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   seq[11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    int   fd_seen;
    logic [10:0] qtmp;

    // Reset state, before any clock edge
    #2;
    chk("reset_q", q, 0);
    chk("reset_cnt", bit_cnt, 0);
    chk("reset_fd", frame_done, 0);
    chk("reset_par", parity, 0);
    chk("reset_soutl", sout_l, 0);
    chk("reset_soutr", sout_r, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Direction, sout, parity and priority vectors
    tbl[0] = '{1'b1, 1'b0, HOLD, 1'b0, 11'h000, 11'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, LOAD, 1'b0, 11'h401, 11'h401, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, SHL,  1'b0, 11'h000, 11'h002, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, LOAD, 1'b0, 11'h401, 11'h401, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, SHR,  1'b1, 11'h000, 11'h600, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, LOAD, 1'b0, 11'h7FF, 11'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, HOLD, 1'b1, 11'h7FF, 11'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, SHL,  1'b1, 11'h7FF, 11'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].clr, tbl[i].en, tbl[i].mode, tbl[i].sin, tbl[i].d);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].eq);
      chk($sformatf("tbl%0d_cnt", i), bit_cnt, tbl[i].ecnt);
      chk($sformatf("tbl%0d_fd", i), frame_done, tbl[i].efd);
      chk($sformatf("tbl%0d_soutl", i), sout_l, tbl[i].esl);
      chk($sformatf("tbl%0d_soutr", i), sout_r, tbl[i].esr);
      chk($sformatf("tbl%0d_par", i), parity, tbl[i].epar);
    end

    // PS/2 receive: 11 strobes spaced 4 cycles apart
    cyc(1, 0, HOLD, 0, 0);
    fd_seen = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(0, 1, SHR, seq[i][0], 0);
      chk($sformatf("ps2_fd_strobe%0d", i), frame_done, (i == 10) ? 1 : 0);
      if (frame_done) fd_seen++;
      if (i == 10) begin
        chk("ps2_q", q, 11'b10001111000);
        qtmp = q;
        chk("ps2_data", qtmp[8:1], 8'h3C);
        chk("ps2_par", parity, 1);  // five ones in the frame
        chk("ps2_cnt", bit_cnt, 0);
      end
      for (int k = 0; k < 3; k++) begin
        cyc(0, 0, SHR, 0, 0);
        if (frame_done) fd_seen++;
      end
    end
    chk("ps2_fd_pulses", fd_seen, 1);
    chk("ps2_q_held", q, 11'b10001111000);

    // Reset mid-frame, asynchronous to the clock
    cyc(1, 0, HOLD, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, SHR, 1, 0);
    chk("arst_pre_q", q, 11'h7C0);
    chk("arst_pre_cnt", bit_cnt, 5);
    en = 0;
    #3 reset = 1'b0;
    #1;
    chk("arst_q", q, 0);
    chk("arst_cnt", bit_cnt, 0);
    chk("arst_fd", frame_done, 0);
    chk("arst_par", parity, 0);
    #1 reset = 1'b1;
    cyc(0, 0, HOLD, 0, 0);
    chk("arst_after_q", q, 0);
    chk("arst_after_fd", frame_done, 0);

    // Load restarts the frame count
    cyc(1, 0, HOLD, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, SHL, 1'($urandom_range(1)), 0);
      chk($sformatf("ldcnt_pre%0d_fd", i), frame_done, 0);
    end
    cyc(0, 1, LOAD, 0, 11'h155);
    chk("ldcnt_load_cnt", bit_cnt, 0);
    for (int i = 0; i < 11; i++) begin
      cyc(0, 1, SHL, 1'($urandom_range(1)), 0);
      chk($sformatf("ldcnt_post%0d_fd", i), frame_done, (i == 10) ? 1 : 0);
    end

    // Continuous strobes on the FRAME_LEN=3 instance
    cyc(1, 0, HOLD, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 1, SHL, 1, 0);
      chk($sformatf("cont%0d_cnt3", k), bit_cnt3, k % 3);
      chk($sformatf("cont%0d_fd3", k), frame_done3, (k % 3 == 0) ? 1 : 0);
    end
    cyc(0, 0, SHL, 1, 0);
    chk("cont_idle_fd3", frame_done3, 0);

    // Randomized run against the reference model
    model_step(1, 0, HOLD, 0, 0);
    cyc(1, 0, HOLD, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic        rc, re, rs;
      shift_mode_t rm;
      logic [10:0] rd;
      rc = ($urandom_range(19) == 0);
      re = ($urandom_range(9) < 7);
      rm = shift_mode_t'($urandom_range(3));
      if (rm == LOAD && $urandom_range(3) != 0) rm = SHR;
      rs = 1'($urandom_range(1));
      rd = 11'($urandom);
      model_step(rc, re, rm, rs, rd);
      cyc(rc, re, rm, rs, rd);
      chk($sformatf("rnd%0d_q", i), q, mq);
      chk($sformatf("rnd%0d_cnt", i), bit_cnt, ms11 % 11);
      chk($sformatf("rnd%0d_fd", i), frame_done, mfd11);
      chk($sformatf("rnd%0d_cnt3", i), bit_cnt3, ms3 % 3);
      chk($sformatf("rnd%0d_fd3", i), frame_done3, mfd3);
      chk($sformatf("rnd%0d_par", i), parity, $countones(mq) % 2);
      chk($sformatf("rnd%0d_soutl", i), sout_l, (mq / 1024) % 2);
      chk($sformatf("rnd%0d_soutr", i), sout_r, mq % 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
